// File: rtl/simp_sector_seq.sv
// Sector-select sequencer: arbitrates CPU/DA requests for the shared SSR pattern and
// applies each new pattern with a break-before-make dead time and a settle interval.
module simp_sector_seq #(
  parameter int DEAD_CYC   = 4,
  parameter int SETTLE_CYC = 8
) (
  input  logic       SIM_CLK,
  input  logic       SIM_RST,
  input  logic       CPU_REQ,
  input  logic [7:0] CPU_SECT,
  input  logic [1:0] CPU_MOD,
  output logic       CPU_ACK,
  output logic       CPU_NAK,
  input  logic       DA_REQ,
  input  logic [7:0] DA_SECT,
  input  logic [1:0] DA_MOD,
  output logic       DA_ACK,
  output logic       DA_NAK,
  output logic       SSR1H,
  output logic       SSR2H,
  output logic       SSR3H,
  output logic       SSR4H,
  output logic       SSR5H,
  output logic       SSR6H,
  output logic       SSR7H,
  output logic       SSR8H,
  output logic       SSR14H,
  output logic       SSR15H,
  output logic       BUSY,
  output logic       LAST_GNT
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DEAD,
    S_SETTLE,
    S_ACK
  } state_t;

  localparam logic [7:0] DEAD_LOAD   = 8'(DEAD_CYC - 1);
  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYC - 1);

  state_t     r_state, w_state_nxt;
  logic [9:0] r_cur, w_cur_nxt;
  logic [9:0] r_new, w_new_nxt;
  logic [9:0] r_ssr, w_ssr_nxt;
  logic [7:0] r_cnt, w_cnt_nxt;
  logic       r_gnt_da, w_gnt_da_nxt;
  logic       r_last_gnt, w_last_gnt_nxt;
  logic       r_mask_cpu, w_mask_cpu_nxt;
  logic       r_mask_da, w_mask_da_nxt;
  logic       r_cpu_ack, w_cpu_ack_nxt;
  logic       r_cpu_nak, w_cpu_nak_nxt;
  logic       r_da_ack, w_da_ack_nxt;
  logic       r_da_nak, w_da_nak_nxt;
  logic       r_busy, w_busy_nxt;

  logic       w_cpu_req, w_da_req, w_sel_da;
  logic [9:0] w_req_pat;

  // A just-served requester is ignored for one IDLE cycle; ties go to whoever was not granted last.
  always_comb begin
    w_cpu_req = CPU_REQ & ~r_mask_cpu;
    w_da_req  = DA_REQ & ~r_mask_da;
    w_sel_da  = w_da_req & (~w_cpu_req | ~r_last_gnt);
    w_req_pat = w_sel_da ? {DA_MOD, DA_SECT} : {CPU_MOD, CPU_SECT};
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_cur_nxt      = r_cur;
    w_new_nxt      = r_new;
    w_cnt_nxt      = r_cnt;
    w_gnt_da_nxt   = r_gnt_da;
    w_last_gnt_nxt = r_last_gnt;
    w_mask_cpu_nxt = 1'b0;
    w_mask_da_nxt  = 1'b0;
    w_cpu_ack_nxt  = 1'b0;
    w_cpu_nak_nxt  = 1'b0;
    w_da_ack_nxt   = 1'b0;
    w_da_nak_nxt   = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_cpu_req | w_da_req) begin
          w_gnt_da_nxt   = w_sel_da;
          w_last_gnt_nxt = w_sel_da;
          w_new_nxt      = w_req_pat;
          if (w_req_pat[9:8] == 2'b11) begin
            w_cpu_nak_nxt  = ~w_sel_da;
            w_da_nak_nxt   = w_sel_da;
            w_mask_cpu_nxt = ~w_sel_da;
            w_mask_da_nxt  = w_sel_da;
          end else if (w_req_pat == r_cur) begin
            w_state_nxt   = S_ACK;
            w_cpu_ack_nxt = ~w_sel_da;
            w_da_ack_nxt  = w_sel_da;
          end else begin
            w_state_nxt = S_DEAD;
            w_cnt_nxt   = DEAD_LOAD;
          end
        end
      end
      S_DEAD: begin
        if (r_cnt == 8'd0) begin
          w_state_nxt = S_SETTLE;
          w_cur_nxt   = r_new;
          w_cnt_nxt   = SETTLE_LOAD;
        end else begin
          w_cnt_nxt = r_cnt - 8'd1;
        end
      end
      S_SETTLE: begin
        if (r_cnt == 8'd0) begin
          w_state_nxt   = S_ACK;
          w_cpu_ack_nxt = ~r_gnt_da;
          w_da_ack_nxt  = r_gnt_da;
        end else begin
          w_cnt_nxt = r_cnt - 8'd1;
        end
      end
      S_ACK: begin
        w_state_nxt    = S_IDLE;
        w_mask_cpu_nxt = ~r_gnt_da;
        w_mask_da_nxt  = r_gnt_da;
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // Drivers only ever see zeros during DEAD; everywhere else they track CUR.
    w_ssr_nxt  = (w_state_nxt == S_DEAD) ? 10'h000 : w_cur_nxt;
    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  always_ff @(posedge SIM_CLK or negedge SIM_RST) begin
    if (!SIM_RST) begin
      r_state    <= S_IDLE;
      r_cur      <= 10'h000;
      r_new      <= 10'h000;
      r_ssr      <= 10'h000;
      r_cnt      <= 8'd0;
      r_gnt_da   <= 1'b0;
      r_last_gnt <= 1'b1;
      r_mask_cpu <= 1'b0;
      r_mask_da  <= 1'b0;
      r_cpu_ack  <= 1'b0;
      r_cpu_nak  <= 1'b0;
      r_da_ack   <= 1'b0;
      r_da_nak   <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cur      <= w_cur_nxt;
      r_new      <= w_new_nxt;
      r_ssr      <= w_ssr_nxt;
      r_cnt      <= w_cnt_nxt;
      r_gnt_da   <= w_gnt_da_nxt;
      r_last_gnt <= w_last_gnt_nxt;
      r_mask_cpu <= w_mask_cpu_nxt;
      r_mask_da  <= w_mask_da_nxt;
      r_cpu_ack  <= w_cpu_ack_nxt;
      r_cpu_nak  <= w_cpu_nak_nxt;
      r_da_ack   <= w_da_ack_nxt;
      r_da_nak   <= w_da_nak_nxt;
      r_busy     <= w_busy_nxt;
    end
  end

  assign SSR1H    = r_ssr[0];
  assign SSR2H    = r_ssr[1];
  assign SSR3H    = r_ssr[2];
  assign SSR4H    = r_ssr[3];
  assign SSR5H    = r_ssr[4];
  assign SSR6H    = r_ssr[5];
  assign SSR7H    = r_ssr[6];
  assign SSR8H    = r_ssr[7];
  assign SSR14H   = r_ssr[8];
  assign SSR15H   = r_ssr[9];
  assign CPU_ACK  = r_cpu_ack;
  assign CPU_NAK  = r_cpu_nak;
  assign DA_ACK   = r_da_ack;
  assign DA_NAK   = r_da_nak;
  assign BUSY     = r_busy;
  assign LAST_GNT = r_last_gnt;

endmodule
